// File: rtl/crc16_denetleyici.sv
// Receive-side CRC-16/XMODEM checker: BLOK_BOYUT payload bytes then CRC high/low byte.
// Latency: crc16_o 1 cycle per byte; bitti_o/gecerli_o/hata_o on the edge after the low CRC byte.
// Backpressure: none, one byte per etkin_i cycle is always accepted; basla_i aborts and restarts.
module crc16_denetleyici #(
    parameter int BLOK_BOYUT = 512
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        basla_i,
    input  logic [7:0]  byte_i,
    input  logic        etkin_i,
    output logic        mesgul_o,
    output logic        bitti_o,
    output logic        gecerli_o,
    output logic        hata_o,
    output logic [15:0] crc16_o,
    output logic [15:0] alinan_crc_o
);

    localparam int CW = (BLOK_BOYUT > 1) ? $clog2(BLOK_BOYUT) : 1;
    localparam logic [CW-1:0] SON_IDX = CW'(BLOK_BOYUT - 1);

    typedef enum logic [1:0] {BOSTA, VERI, CRC_Y, CRC_D} durum_t;

    durum_t          durum_q, durum_d;
    logic [15:0]     crc_q, crc_d;
    logic [15:0]     alinan_q, alinan_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            son_q, son_d;
    logic            bitti_q, bitti_d;
    logic            gecerli_q, gecerli_d;
    logic            hata_q, hata_d;

    // Full 8-bit MSB-first update of polynomial 0x1021, unrolled into one cycle.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        durum_d   = durum_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        alinan_d  = alinan_q;
        son_d     = 1'b0;
        bitti_d   = son_q;
        gecerli_d = gecerli_q;
        hata_d    = hata_q;
        // son_q marks the cycle after the low CRC byte; the compare is registered from here.
        if (son_q) begin
            gecerli_d = (alinan_q == crc_q);
            hata_d    = (alinan_q != crc_q);
        end
        if (basla_i) begin
            durum_d   = VERI;
            crc_d     = 16'h0000;
            cnt_d     = '0;
            alinan_d  = 16'h0000;
            gecerli_d = 1'b0;
            hata_d    = 1'b0;
            bitti_d   = 1'b0;
        end else if (etkin_i) begin
            case (durum_q)
                VERI: begin
                    crc_d = crc_byte(crc_q, byte_i);
                    if (cnt_q == SON_IDX) durum_d = CRC_Y;
                    else                  cnt_d   = cnt_q + CW'(1);
                end
                CRC_Y: begin
                    alinan_d[15:8] = byte_i;
                    durum_d        = CRC_D;
                end
                CRC_D: begin
                    alinan_d[7:0] = byte_i;
                    durum_d       = BOSTA;
                    son_d         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q   <= BOSTA;
            crc_q     <= 16'h0000;
            alinan_q  <= 16'h0000;
            cnt_q     <= '0;
            son_q     <= 1'b0;
            bitti_q   <= 1'b0;
            gecerli_q <= 1'b0;
            hata_q    <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            crc_q     <= crc_d;
            alinan_q  <= alinan_d;
            cnt_q     <= cnt_d;
            son_q     <= son_d;
            bitti_q   <= bitti_d;
            gecerli_q <= gecerli_d;
            hata_q    <= hata_d;
        end
    end

    assign mesgul_o     = (durum_q != BOSTA);
    assign bitti_o      = bitti_q;
    assign gecerli_o    = gecerli_q;
    assign hata_o       = hata_q;
    assign crc16_o      = crc_q;
    assign alinan_crc_o = alinan_q;

endmodule
